// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle for the fetch buffer.
// The buffer takes the slave view; the fetch stage, instruction memory and
// decode stage together form the master view.
interface fetch_buffer_if #(
   parameter int MEM_DEPTH = 16
);
   logic                 fetch_valid;
   logic [MEM_DEPTH-1:0] fetch_pc;
   logic [31:0]          imem_rdata;
   logic                 fetch_stall;
   logic                 id_valid;
   logic [31:0]          id_instr;
   logic [MEM_DEPTH-1:0] id_pc;
   logic                 id_ready;

   modport slave (
      input  fetch_valid, fetch_pc, imem_rdata, id_ready,
      output fetch_stall, id_valid, id_instr, id_pc
   );

   modport master (
      output fetch_valid, fetch_pc, imem_rdata, id_ready,
      input  fetch_stall, id_valid, id_instr, id_pc
   );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: holds the PC of each accepted request for one
// cycle until memory returns the word, then queues {pc, instr} for decode.
// Back-pressure counts the in-flight request, so the queue cannot overflow.
module fetch_buffer #(
   parameter int MEM_DEPTH = 16,
   parameter int DEPTH     = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   fetch_buffer_if.slave          bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [31:0]          instr_mem [DEPTH];
   logic [MEM_DEPTH-1:0] pc_mem    [DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic                 pending_v;
   logic [MEM_DEPTH-1:0] pending_pc;
   logic                 stall;
   logic                 accept;
   logic                 push;
   logic                 pop;

   // Handshake decode; stall looks only at registered count and pending_v
   always_comb begin
      stall  = (count == FULL) || ((count == FULL - CNT_ONE) && pending_v);
      accept = bus.fetch_valid && !stall && !flush;
      push   = pending_v && !flush;
      pop    = (count != '0) && bus.id_ready && !flush;
   end

   // Control state: pointers, occupancy and the in-flight marker
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         pending_v <= 1'b0;
      end else if (flush) begin
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         pending_v <= 1'b0;
      end else begin
         pending_v <= accept;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push) begin
            count <= count - CNT_ONE;
         end
      end
   end

   // Datapath storage: pending PC and queue entries carry no reset
   always_ff @(posedge clock) begin
      if (accept) begin
         pending_pc <= bus.fetch_pc;
      end
      if (push) begin
         instr_mem[wr_ptr] <= bus.imem_rdata;
         pc_mem[wr_ptr]    <= pending_pc;
      end
   end

   // Decode side is driven purely from the head entry in storage
   always_comb begin
      bus.fetch_stall = stall;
      bus.id_valid    = (count != '0);
      bus.id_instr    = instr_mem[rd_ptr];
      bus.id_pc       = pc_mem[rd_ptr];
   end

   overflow_check : assert property (
      @(posedge clock) disable iff (!reset) (push |-> (count != FULL))
   ) else $error("fetch_buffer write into full queue");
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=4, MEM_DEPTH=16).
// Instruction memory returns {~pc, pc} one cycle after the address.
module tb_fetch_buffer;
   localparam int MEM_DEPTH = 16;
   localparam int DEPTH     = 4;
   localparam int WRAP_N    = 16;
   localparam logic [5:0] STALL_EXP = 6'b111000;
   localparam int CNT_EXP [6] = '{0, 1, 2, 3, 4, 4};

   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic                   flush = 1'b0;
   logic [$clog2(DEPTH):0] count;
   int                     checks = 0;
   int                     errors = 0;
   logic [15:0]            pc_next;
   logic                   prev_stall;

   fetch_buffer_if #(.MEM_DEPTH(MEM_DEPTH)) bus ();

   fetch_buffer #(.MEM_DEPTH(MEM_DEPTH), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .count (count),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] instr_of(input logic [15:0] pc);
      return {~pc, pc};
   endfunction

   // Instruction memory with one cycle read latency
   always @(posedge clock) bus.imem_rdata <= instr_of(bus.fetch_pc);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bus.fetch_valid = 1'b0;
      bus.fetch_pc    = '0;
      bus.id_ready    = 1'b0;

      // Reset held low across clock edges
      #2;
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(bus.id_valid), 32'd0);
      check("rst_stall", 32'(bus.fetch_stall), 32'd0);
      cycle();
      cycle();
      check("rst_count_hold", 32'(count), 32'd0);

      // Streaming 0,4,8,12 with decode always ready
      reset = 1'b1;
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 16'h0;
      bus.id_ready    = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check("seq_valid", 32'(bus.id_valid), 32'((k >= 1) && (k <= 4)));
         if ((k >= 1) && (k <= 4)) begin
            check("seq_pc", 32'(bus.id_pc), 32'(4 * (k - 1)));
            check("seq_instr", bus.id_instr, instr_of(16'(4 * (k - 1))));
            check("seq_count", 32'(count), 32'd1);
         end
         bus.fetch_valid = ((k + 1) < 4);
         bus.fetch_pc    = 16'(4 * (k + 1));
      end

      // Fill with decode stalled; fetch holds PC while stalled
      bus.id_ready    = 1'b0;
      bus.fetch_valid = 1'b1;
      pc_next         = 16'h100;
      bus.fetch_pc    = pc_next;
      prev_stall      = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (!prev_stall) pc_next = pc_next + 16'd4;
         check("fill_stall", 32'(bus.fetch_stall), 32'(STALL_EXP[k]));
         check("fill_count", 32'(count), 32'(CNT_EXP[k]));
         prev_stall   = bus.fetch_stall;
         bus.fetch_pc = pc_next;
      end
      check("fill_accepted", 32'(pc_next), 32'h110);
      bus.fetch_valid = 1'b0;
      bus.id_ready    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", 32'(bus.id_valid), 32'd1);
         check("drain_pc", 32'(bus.id_pc), 32'(16'h100 + 16'(4 * i)));
         cycle();
      end
      check("drain_empty", 32'(bus.id_valid), 32'd0);
      check("drain_stall", 32'(bus.fetch_stall), 32'd0);

      // Simultaneous push and pop at count 2 across several pointer wraps
      bus.id_ready    = 1'b0;
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 16'h200;
      for (int k = 0; k <= WRAP_N; k++) begin
         cycle();
         if (k >= 2) begin
            check("wrap_count", 32'(count), 32'd2);
            check("wrap_pc", 32'(bus.id_pc), 32'(16'h200 + 16'(4 * (k - 2))));
         end
         bus.id_ready    = ((k + 1) >= 3);
         bus.fetch_valid = ((k + 1) < WRAP_N);
         bus.fetch_pc    = 16'h200 + 16'(4 * (k + 1));
      end
      cycle();
      check("wrap_tail_count", 32'(count), 32'd1);
      check("wrap_tail_pc", 32'(bus.id_pc), 32'h23C);
      check("wrap_tail_instr", bus.id_instr, instr_of(16'h23C));
      cycle();
      check("wrap_empty", 32'(count), 32'd0);

      // Flush discards the queued 0x10 and in-flight 0x14, ignores 0x18
      bus.id_ready    = 1'b0;
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 16'h10;
      cycle();
      bus.fetch_pc = 16'h14;
      cycle();
      check("pre_flush_count", 32'(count), 32'd1);
      flush           = 1'b1;
      bus.fetch_pc    = 16'h18;
      bus.id_ready    = 1'b1;
      cycle();
      check("flush_count", 32'(count), 32'd0);
      check("flush_valid", 32'(bus.id_valid), 32'd0);
      check("flush_stall", 32'(bus.fetch_stall), 32'd0);
      flush        = 1'b0;
      bus.id_ready = 1'b0;
      bus.fetch_pc = 16'h40;
      cycle();
      check("post_flush_none", 32'(count), 32'd0);
      bus.fetch_valid = 1'b0;
      cycle();
      check("post_flush_count", 32'(count), 32'd1);
      check("post_flush_pc", 32'(bus.id_pc), 32'h40);
      check("post_flush_instr", bus.id_instr, instr_of(16'h40));
      bus.id_ready = 1'b1;
      cycle();
      check("post_flush_empty", 32'(count), 32'd0);

      // Asynchronous reset with three queued entries and one in flight
      bus.id_ready    = 1'b0;
      bus.fetch_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.fetch_pc = 16'h300 + 16'(4 * k);
         cycle();
      end
      check("mid_count", 32'(count), 32'd3);
      check("mid_stall", 32'(bus.fetch_stall), 32'd1);
      bus.fetch_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("async_count", 32'(count), 32'd0);
      check("async_valid", 32'(bus.id_valid), 32'd0);
      check("async_stall", 32'(bus.fetch_stall), 32'd0);
      cycle();
      check("async_hold", 32'(count), 32'd0);
      reset           = 1'b1;
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 16'h500;
      cycle();
      check("rel_no_stale", 32'(count), 32'd0);
      bus.fetch_valid = 1'b0;
      cycle();
      check("rel_count", 32'(count), 32'd1);
      check("rel_pc", 32'(bus.id_pc), 32'h500);
      check("rel_instr", bus.id_instr, instr_of(16'h500));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter MEM_DEPTH, default 16, width of instruction address / PC fields.
REQ-002 Parameter DEPTH, default 4, number of queue entries; power of two, >= 2.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 fetch_valid  input  1  fetch stage presents an instruction address this cycle.
REQ-006 fetch_pc  input  MEM_DEPTH  address presented to instruction memory this cycle.
REQ-007 imem_rdata  input  32  instruction word, valid one cycle after its address.
REQ-008 fetch_stall  output  1  fetch stage shall hold its PC and issue no request.
REQ-009 flush  input  1  synchronous discard of all queued and in-flight instructions.
REQ-010 id_valid  output  1  head entry is valid for decode.
REQ-011 id_instr  output  32  instruction word of head entry.
REQ-012 id_pc  output  MEM_DEPTH  PC of head entry.
REQ-013 id_ready  input  1  decode accepts head entry this cycle.
REQ-014 count  output  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-015 A request is accepted in cycle t when fetch_valid=1, fetch_stall=0 and flush=0.
REQ-016 On acceptance, fetch_pc shall be latched into a pending register and pending_v set for cycle t+1.
REQ-017 In cycle t+1 with pending_v=1 and flush=0, {pending_pc, imem_rdata} shall be written to the queue tail; pending_v clears unless a new request is accepted in t+1.
REQ-018 Back-to-back requests in consecutive cycles shall be sustained at one per cycle while fetch_stall=0.
REQ-019 Minimum latency: request in cycle t -> id_valid=1 with that entry in cycle t+2; no bypass from imem_rdata to id_* outputs.
REQ-020 id_valid shall equal (count != 0); id_instr/id_pc shall be driven from the head entry, registered storage only.
REQ-021 Pop occurs when id_valid=1 and id_ready=1; head advances next cycle.
REQ-022 id_ready with count=0 shall have no effect.
REQ-023 fetch_stall = (count + pending_v) >= DEPTH, derived from registered state only; no combinational path from id_ready or fetch_valid.
REQ-024 Push and pop in the same cycle shall leave count unchanged and preserve order.
REQ-025 Read/write pointers shall be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-026 Queue shall never overflow: a write with count=DEPTH is unreachable by REQ-023 and shall be flagged by an assertion.
REQ-027 Entries leave in strict FIFO order; id_pc of consecutive entries equals the accepted fetch_pc sequence.
REQ-028 flush=1 in cycle t: next cycle count=0, pending_v=0, pointers=0, id_valid=0; fetch_valid and imem_rdata in cycle t ignored.
REQ-029 flush overrides simultaneous push, pop and request.
REQ-030 fetch_stall shall be 0 in the cycle after flush.

Reset
REQ-031 reset=0 shall immediately clear count, pending_v, read and write pointers; id_valid=0, fetch_stall=0, count=0 while asserted.
REQ-032 id_instr and id_pc are don't-care while id_valid=0; queue storage needs no reset.
REQ-033 A request in flight when reset asserts shall be discarded; no entry appears after release.
REQ-034 First request may be accepted in the first rising edge after reset deasserts.

Verification
REQ-035 Reset, then fetch_valid=1 with fetch_pc 0,4,8,12, id_ready=1 -> id_valid from cycle 2, id_pc 0,4,8,12 on consecutive cycles with matching imem_rdata words.
REQ-036 DEPTH=4, id_ready=0, continuous requests -> fetch_stall=1 once count+pending_v=4; count saturates at 4; no address lost or duplicated after id_ready=1.
REQ-037 Queue at count=2, push and pop in same cycle -> count stays 2, order preserved; repeat across pointer wrap (>= 3*DEPTH entries).
REQ-038 Requests at pc 0x10,0x14, flush asserted in cycle after 0x14 accepted -> count=0, id_valid=0 next cycle; instruction for 0x14 never appears; next request pc 0x40 emerges first.
REQ-039 reset driven low mid-stream with count=3 and pending_v=1 -> count=0, id_valid=0 asynchronously; after release first id_pc is the first post-reset fetch_pc.
REQ-040 Random fetch_valid/id_ready/flush stimulus vs. reference queue model -> id_pc/id_instr sequence matches, overflow assertion never fires.
